// File: rtl/xgmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// xgmii_tx_arbiter
//
// Shares one 64-bit XGMII TX lane between two frame sources: src0 (measurement
// traffic generator) and src1 (control traffic such as ARP/ND replies).
// Grants are only made on frame boundaries, a granted frame is never stalled
// mid-frame, a minimum idle gap is enforced after every frame, and per-source
// frame counters plus an underrun counter are kept.
//
// Optional build macro:
//   ARB_RR_EN  - round-robin arbitration in IDLE (pointer flips to the other
//                source after every completed or aborted frame). When not
//                defined, src1 always has strict priority over src0.
//
// Parameters:
//   MIN_IFG  minimum idle words after every frame (floor for tx_ifg)
//   CNT_W    width of the frame / underrun counters
//
// Ports:
//   sys_clk      in   XGMII clock (156.25 MHz), sole clock
//   sys_rst      in   asynchronous active-high reset
//   tx_enable    in   0: finish the current frame, then grant nothing
//   tx_ifg       in   requested idle words between frames (sampled at frame end)
//   srcN_txd     in   source data word
//   srcN_txc     in   source control lanes
//   srcN_valid   in   source word valid / frame pending
//   srcN_last    in   word carries terminate and ends the frame
//   srcN_ready   out  source word accepted this cycle
//   xgmii_txd    out  registered XGMII TX data to the PHY
//   xgmii_txc    out  registered XGMII TX control to the PHY
//   busy         out  arbiter is not IDLE
//   src0_frames  out  frames completed from src0 (wraps)
//   src1_frames  out  frames completed from src1 (wraps)
//   underruns    out  frames aborted by a mid-frame valid drop (wraps)
// -----------------------------------------------------------------------------
module xgmii_tx_arbiter #(
  parameter int MIN_IFG = 3,
  parameter int CNT_W   = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tx_enable,
  input  logic [15:0]      tx_ifg,
  input  logic [63:0]      src0_txd,
  input  logic [7:0]       src0_txc,
  input  logic             src0_valid,
  input  logic             src0_last,
  output logic             src0_ready,
  input  logic [63:0]      src1_txd,
  input  logic [7:0]       src1_txc,
  input  logic             src1_valid,
  input  logic             src1_last,
  output logic             src1_ready,
  output logic [63:0]      xgmii_txd,
  output logic [7:0]       xgmii_txc,
  output logic             busy,
  output logic [CNT_W-1:0] src0_frames,
  output logic [CNT_W-1:0] src1_frames,
  output logic [CNT_W-1:0] underruns
);

  localparam logic [63:0]      IDLE_TXD  = 64'h0707070707070707;
  localparam logic [7:0]       IDLE_TXC  = 8'hFF;
  localparam logic [63:0]      ERR_TXD   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]       ERR_TXC   = 8'hFF;
  localparam logic [15:0]      MIN_IFG_W = 16'(MIN_IFG);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;        // 0: src0 owns the lane, 1: src1
  logic [15:0]      gap_q, gap_d;        // remaining GAP cycles minus one
  logic [63:0]      txd_q, txd_d;
  logic [7:0]       txc_q, txc_d;
  logic [CNT_W-1:0] f0_q, f1_q, ur_q;

  logic             win;
  logic             sel;
  logic             sel_valid;
  logic             sel_last;
  logic [63:0]      sel_txd;
  logic [7:0]       sel_txc;
  logic             arb_req;
  logic [15:0]      ifg_eff;
  logic             accept;
  logic             frame_done;
  logic             abort;

  // ---------------------------------------------------------------------------
  // Arbitration winner for a new frame (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic rr_q;   // source that wins a tie

  always_comb begin
    if (src0_valid && src1_valid) begin
      win = rr_q;
    end else begin
      win = src1_valid;
    end
  end

  // Pointer moves to the source that was not just served, so a backlog on both
  // sides alternates.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_q <= 1'b0;
    end else if (frame_done || abort) begin
      rr_q <= ~sel;
    end
  end
`else
  // Fixed priority: src1 (control traffic) always first.
  assign win = src1_valid;
`endif

  assign arb_req = tx_enable && (src0_valid || src1_valid);

  // In IDLE the freshly chosen winner drives the lane in the same cycle;
  // afterwards the registered grant holds it until the frame ends.
  assign sel       = (state_q == ST_IDLE) ? win : gnt_q;
  assign sel_valid = sel ? src1_valid : src0_valid;
  assign sel_last  = sel ? src1_last  : src0_last;
  assign sel_txd   = sel ? src1_txd   : src0_txd;
  assign sel_txc   = sel ? src1_txc   : src0_txc;

  assign ifg_eff = (tx_ifg < MIN_IFG_W) ? MIN_IFG_W : tx_ifg;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gap_d      = gap_q;
    txd_d      = IDLE_TXD;
    txc_d      = IDLE_TXC;
    accept     = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_req) begin
          gnt_d   = win;
          accept  = 1'b1;
          state_d = ST_XMIT;
          if (sel_last) begin
            frame_done = 1'b1;
          end
        end
      end

      ST_XMIT: begin
        if (sel_valid) begin
          accept = 1'b1;
          if (sel_last) begin
            frame_done = 1'b1;
          end
        end else begin
          abort = 1'b1;
        end
      end

      ST_GAP: begin
        // gap_q counts down to zero; the final GAP cycle hands over to IDLE so
        // the next granted word lands right after the last idle word.
        if (gap_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      txd_d = sel_txd;
      txc_d = sel_txc;
    end

    if (abort) begin
      txd_d = ERR_TXD;
      txc_d = ERR_TXC;
    end

    // Gap is counted from the cycle after the last word leaves the register,
    // hence the load of ifg_eff-1 (the first GAP cycle still shows that word).
    if (frame_done || abort) begin
      state_d = ST_GAP;
      gap_d   = ifg_eff - 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State, grant, gap counter and output word registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      gap_q   <= 16'd0;
      txd_q   <= IDLE_TXD;
      txc_q   <= IDLE_TXC;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      txc_q   <= txc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters (wrap modulo 2^CNT_W)
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      f0_q <= '0;
      f1_q <= '0;
      ur_q <= '0;
    end else begin
      if (frame_done) begin
        if (sel) begin
          f1_q <= f1_q + CNT_ONE;
        end else begin
          f0_q <= f0_q + CNT_ONE;
        end
      end
      if (abort) begin
        ur_q <= ur_q + CNT_ONE;
      end
    end
  end

  // Ready is combinational from state/valid; it is masked while reset is held
  // because the state register already reads IDLE during reset.
  assign src0_ready  = accept && !sel && !sys_rst;
  assign src1_ready  = accept &&  sel && !sys_rst;

  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign busy        = (state_q != ST_IDLE);
  assign src0_frames = f0_q;
  assign src1_frames = f1_q;
  assign underruns   = ur_q;

endmodule
